// File: rtl/core_wakeup_seq.sv
// core_wakeup_seq: core power-up sequencer (INIT -> [WAIT_INT] -> HOLD -> RUN) with synchronized
//   core reset release and reset-gated synchronization of async interrupt/debug events.
// Latency: spc_grst_l rises SyncStages cycles after RUN entry; events take SyncStages cycles to cross.
// Backpressure: none; all outputs are levels.
//
// Ports:
//   clk_i, reset_l            clock and async active-low reset
//   init_done_i               early SRAM-init-complete indication (synchronous)
//   wake_int_i                single-cycle wake-up pulse on interrupt return (synchronous)
//   irq_i, ipi_i, time_irq_i, debug_req_i   async event inputs
//   spc_grst_l                synchronized core reset, active-low
//   irq_o, ipi_o, time_irq_o, debug_req_o   synchronized events, forced to 0 while core in reset
//   state_o                   FSM state (INIT=0, WAIT_INT=1, HOLD=2, RUN=3)
//   wake_cnt_o                SRAM-init wait counter
//
// Build option: define CORE_WAKEUP_WAIT_INT_EN to insert the WAIT_INT state, which holds the core
// in reset until a wake-up interrupt has been seen. Undefined: INIT goes straight to HOLD.

module core_wakeup_seq #(
    parameter int CntWidth      = 16,
    parameter int NrIrq         = 2,
    parameter int SyncStages    = 2,
    parameter int RstHoldCycles = 4
) (
    input  logic                clk_i,
    input  logic                reset_l,
    input  logic                init_done_i,
    input  logic                wake_int_i,
    input  logic [NrIrq-1:0]    irq_i,
    input  logic                ipi_i,
    input  logic                time_irq_i,
    input  logic                debug_req_i,
    output logic                spc_grst_l,
    output logic [NrIrq-1:0]    irq_o,
    output logic                ipi_o,
    output logic                time_irq_o,
    output logic                debug_req_o,
    output logic [1:0]          state_o,
    output logic [CntWidth-1:0] wake_cnt_o
);

    localparam int EvW = NrIrq + 3;

`ifdef CORE_WAKEUP_WAIT_INT_EN
    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_WAIT_INT = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RUN      = 2'd3
    } state_e;
    localparam state_e InitExitState = ST_WAIT_INT;
`else
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;
    localparam state_e InitExitState = ST_HOLD;
`endif

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [7:0]            hold_q, hold_d;
    logic                  cnt_sat;
    logic                  init_exit;

    assign cnt_sat   = cnt_q[CntWidth-1];
    // Either source ends INIT; both together still produce one exit.
    assign init_exit = cnt_sat | init_done_i;

`ifdef CORE_WAKEUP_WAIT_INT_EN
    logic wake_seen_q, wake_seen_d;
`else
    logic unused_wake_int;
    assign unused_wake_int = wake_int_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
`ifdef CORE_WAKEUP_WAIT_INT_EN
        // Sticky: a wake pulse arriving during INIT must not be lost.
        wake_seen_d = wake_seen_q | (wake_int_i & (state_q != ST_RUN));
`endif
        case (state_q)
            ST_INIT: begin
                // Saturate on MSB so the counter never wraps.
                if (!cnt_sat) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
                if (init_exit) begin
                    state_d = InitExitState;
                end
            end
`ifdef CORE_WAKEUP_WAIT_INT_EN
            ST_WAIT_INT: begin
                if (wake_seen_q) begin
                    state_d = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                hold_d = hold_q + 8'd1;
                if (hold_q == 8'(RstHoldCycles - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

`ifdef CORE_WAKEUP_WAIT_INT_EN
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            wake_seen_q <= 1'b0;
        end else begin
            wake_seen_q <= wake_seen_d;
        end
    end
`endif

    // Core reset release: asserts asynchronously with reset_l, deasserts through the synchronizer.
    logic                  grst_raw;
    logic [SyncStages-1:0] rst_sync_q;

    assign grst_raw = (state_q == ST_RUN) & reset_l;

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SyncStages-2:0], grst_raw};
        end
    end

    assign spc_grst_l = rst_sync_q[SyncStages-1];

    // Event synchronizers: one independent flop chain per bit.
    logic [EvW-1:0]                 ev_raw;
    logic [SyncStages-1:0][EvW-1:0] ev_sync_q;
    logic [EvW-1:0]                 ev_out;

    assign ev_raw = {irq_i, ipi_i, time_irq_i, debug_req_i};

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            ev_sync_q <= '0;
        end else begin
            ev_sync_q <= {ev_sync_q[SyncStages-2:0], ev_raw};
        end
    end

    // Events are meaningless to a core still in reset, so hold them low until release.
    assign ev_out = spc_grst_l ? ev_sync_q[SyncStages-1] : '0;

    assign irq_o       = ev_out[EvW-1:3];
    assign ipi_o       = ev_out[2];
    assign time_irq_o  = ev_out[1];
    assign debug_req_o = ev_out[0];

    assign state_o    = state_q;
    assign wake_cnt_o = cnt_q;

endmodule

// File: doc/core_wakeup_seq.md
CORE_WAKEUP_SEQ -- requirements
Module: core_wakeup_seq

Interface
REQ-001 The block SHALL have parameter CntWidth, default 16, giving the SRAM-init wait counter width; the wait ends when counter MSB sets (2^(CntWidth-1) cycles).
REQ-002 The block SHALL have parameter NrIrq, default 2, giving the number of level-sensitive irq lines.
REQ-003 The block SHALL have parameter SyncStages, default 2 (legal 2..4), giving the flop depth of every synchronizer.
REQ-004 The block SHALL have parameter RstHoldCycles, default 4 (legal 1..255), giving the cycles spent in HOLD before RUN.
REQ-005 The block SHALL have port clk_i, input, 1 bit: clock.
REQ-006 The block SHALL have port reset_l, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port init_done_i, input, 1 bit: early SRAM-init-complete indication, synchronous.
REQ-008 The block SHALL have port wake_int_i, input, 1 bit: single-cycle pulse on L15 interrupt return (wake-up), synchronous.
REQ-009 The block SHALL have port irq_i, input, NrIrq bits: async interrupt lines.
REQ-010 The block SHALL have ports ipi_i, time_irq_i and debug_req_i, input, 1 bit each: async events.
REQ-011 The block SHALL have port spc_grst_l, output, 1 bit: synchronized core reset, active-low.
REQ-012 The block SHALL have ports irq_o (NrIrq bits), ipi_o, time_irq_o and debug_req_o, output: synchronized and gated events.
REQ-013 The block SHALL have port state_o, output, 2 bits: FSM state (INIT=0, WAIT_INT=1, HOLD=2, RUN=3).
REQ-014 The block SHALL have port wake_cnt_o, output, CntWidth bits: current wait counter value.

Function
REQ-015 In INIT, the counter SHALL increment by 1 each cycle and saturate once MSB=1, with no wrap.
REQ-016 INIT SHALL exit on the cycle after counter MSB=1 or init_done_i=1, whichever is first, going to WAIT_INT (macro defined) or HOLD (macro undefined).
REQ-017 A wake_int_i pulse in any state before RUN SHALL set a sticky wake_seen flag; wake_seen=1 in WAIT_INT SHALL cause a transition to HOLD next cycle.
REQ-018 HOLD SHALL last exactly RstHoldCycles cycles, counted by an 8-bit hold counter, then go to RUN.
REQ-019 RUN SHALL be terminal until reset_l asserts.
REQ-020 Raw core reset SHALL be (state==RUN) AND reset_l, passed through a SyncStages-deep synchronizer to spc_grst_l; spc_grst_l SHALL rise SyncStages cycles after RUN entry.
REQ-021 Each of irq_i, ipi_i, time_irq_i and debug_req_i SHALL pass through its own SyncStages synchronizer.
REQ-022 Event outputs SHALL be forced to 0 while spc_grst_l=0 and equal the synchronized value otherwise.
REQ-023 init_done_i and counter saturation in the same cycle SHALL produce a single exit, with no double transition.
REQ-024 wake_int_i during HOLD or RUN SHALL have no state effect.

Reset
REQ-025 Asserting reset_l SHALL asynchronously force: state=INIT, counter=0, hold counter=0, wake_seen=0, all synchronizer flops=0, spc_grst_l=0, all event outputs=0, state_o=0, wake_cnt_o=0.
REQ-026 Reset mid-operation, in any state, SHALL restart the full sequence from INIT with counter 0.
REQ-027 Deassertion SHALL take effect on the first clk_i edge after reset_l rises, and the counter SHALL be 1 after that edge.

Configuration
REQ-028 Macro CORE_WAKEUP_WAIT_INT_EN SHALL control the wake-up interrupt gate.
REQ-029 With CORE_WAKEUP_WAIT_INT_EN defined, INIT->WAIT_INT SHALL apply and release SHALL require a wake-up interrupt.
REQ-030 With CORE_WAKEUP_WAIT_INT_EN undefined, WAIT_INT and wake_seen SHALL not exist, INIT SHALL go directly to HOLD, and wake_int_i SHALL be ignored.

Verification
REQ-031 The bench SHALL cover: CntWidth=4, RstHoldCycles=4, SyncStages=2, macro off, release reset -> state_o=2 after 9 edges, 3 after 13, spc_grst_l=1 after 15.
REQ-032 The bench SHALL cover: macro on, wake_int_i pulse at cycle 3 (during INIT) -> wake_seen kept, WAIT_INT held one cycle, then HOLD; spc_grst_l=1 at cycle 16.
REQ-033 The bench SHALL cover: macro on, no wake_int_i -> state_o stays 1 for 1000 cycles and spc_grst_l stays 0.
REQ-034 The bench SHALL cover: init_done_i=1 at cycle 2 with CntWidth=16 -> state leaves INIT at cycle 3, and wake_cnt_o freezes at 2 or 3, never wrapping.
REQ-035 The bench SHALL cover: irq_i=2'b11 held from reset -> irq_o=0 until spc_grst_l=1, then 2'b11 on the same cycle.
REQ-036 The bench SHALL cover: reset_l low for 1 cycle while in RUN -> spc_grst_l=0 immediately, state_o=0, and the full sequence repeats with identical timing.
